image_buf_writer: RTL

Capture-side writer for the frame buffer that the display-side address generator reads. Accepts a raster pixel stream from the camera/video input and decimates it by 2^DIV_BY in both axes. Produces registered write address, data and enable into the dual-port image BRAM, using the same address map the read side uses: addr = (x>>DIV_BY) + (y>>DIV_BY)*(640>>DIV_BY). Supports single-frame or continuous capture and reports frame completion.

---
 rtl/image_pkg.sv | 12 +
 rtl/raster_counter.sv | 36 +++
 rtl/image_buf_writer.sv | 108 ++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// image_pkg: frame-buffer geometry defaults, capture states and the shared pixel address map
package image_pkg;
  localparam int DEF_H_ACT = 640;
  localparam int DEF_V_ACT = 480;
  localparam int ADDR_W = 19;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, CAPTURE = 2'd2} cap_state_t;
  function automatic logic [ADDR_W-1:0] addr_of(input logic [9:0] x, input logic [9:0] y, input int div, input int h);
    logic [ADDR_W-1:0] w;
    w = ADDR_W'(h >> div);
    return ADDR_W'(x >> div) + ADDR_W'(y >> div) * w;
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: saturating x/y raster position of the current pixel with decimation keep flag
module raster_counter #(
  parameter int DIV_BY = 1,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       restart,
  input  logic       eol,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       keep,
  output logic       last_line,
  output logic       open
);
  localparam logic [9:0] MSK = 10'((1 << DIV_BY) - 1);
  localparam logic [9:0] HA = 10'(H_ACT);
  localparam logic [9:0] VA = 10'(V_ACT);
  logic [9:0] x, y;
  assign px = restart ? '0 : x;
  assign py = restart ? '0 : y;
  assign keep = px < HA && py < VA && ((px | py) & MSK) == '0;
  assign last_line = py == VA - 10'd1;
  assign open = y < VA;
  // step past the accepted pixel, clamping both counters at their ceiling
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      x <= eol ? '0 : px + {9'd0, px != '1};
      y <= eol ? py + {9'd0, py != '1} : py;
    end
endmodule

// File: rtl/image_buf_writer.sv
// image_buf_writer: decimating raster capture into the frame buffer; define PIX_AVG_EN for horizontal pair averaging
module image_buf_writer import image_pkg::*; #(
  parameter int DIV_BY = 1,
  parameter int PIX_W = 12,
  parameter int H_ACT = DEF_H_ACT,
  parameter int V_ACT = DEF_V_ACT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_req,
  input  logic              cap_cont,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_eol,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done
);
  cap_state_t state, nxt;
  logic cont_r;
  logic [9:0] px, py;
  logic keep, last_line, open;
  logic in_wait, in_cap, sof_hit, end_sof, end_eol, done_n, drop, adv, take, put;
  logic w_en;
  logic [ADDR_W-1:0] w_addr, cur_addr;
  logic [PIX_W-1:0] w_data;
  assign in_wait = state == WAIT_SOF;
  assign in_cap = state == CAPTURE;
  assign sof_hit = pix_valid & pix_sof;
  assign end_sof = in_cap & sof_hit & open;
  assign end_eol = in_cap & pix_valid & pix_eol & !pix_sof & last_line;
  assign done_n = end_sof | end_eol;
  assign drop = end_sof & !cont_r;
  assign adv = (in_wait & sof_hit) | (in_cap & pix_valid);
  assign take = adv & !drop;
  assign put = take & keep;
  assign cur_addr = addr_of(px, py, DIV_BY, H_ACT);
  assign busy = state != IDLE;

  raster_counter #(.DIV_BY(DIV_BY), .H_ACT(H_ACT), .V_ACT(V_ACT)) u_rc (
    .clk(clk), .reset_n(reset_n), .adv(adv), .restart(sof_hit), .eol(pix_eol),
    .px(px), .py(py), .keep(keep), .last_line(last_line), .open(open)
  );

`ifdef PIX_AVG_EN
  localparam bit AVG = DIV_BY > 0;
  logic pend, flush;
  logic [ADDR_W-1:0] pend_addr;
  logic [PIX_W-1:0] pend_data;
  logic [PIX_W:0] sum;
  assign sum = {1'b0, pend_data} + {1'b0, pix_data};
  assign flush = pend & adv;
  assign w_en = flush | (put & (!AVG | pix_eol));
  assign w_addr = flush ? pend_addr : cur_addr;
  assign w_data = flush ? (sof_hit ? pend_data : sum[PIX_W:1]) : pix_data;
  // park a kept pixel until its right-hand partner (or a line/frame break) arrives
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      if (adv) pend <= put & AVG & !pix_eol;
      if (put) begin
        pend_addr <= cur_addr;
        pend_data <= pix_data;
      end
    end
`else
  assign w_en = put;
  assign w_addr = cur_addr;
  assign w_data = pix_data;
`endif

  // capture state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;

  // arm on request, start at SOF, fall back to idle at a single-shot frame end
  always_comb begin
    nxt = state;
    if (state == IDLE && cap_req) nxt = WAIT_SOF;
    if (in_wait && sof_hit) nxt = CAPTURE;
    if (done_n && !cont_r) nxt = IDLE;
  end

  // registered write port, frame-end pulse and per-frame continuous-mode sample
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cont_r <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_done <= 1'b0;
    end else begin
      if (take & sof_hit) cont_r <= cap_cont;
      wr_en <= w_en;
      if (w_en) begin
        wr_addr <= w_addr;
        wr_data <= w_data;
      end
      frame_done <= done_n;
    end
endmodule
